// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
// Contents:
//   arb_state_e : arbiter FSM state encoding (IDLE / GRANT / STALL)
//   STAT_W      : width of every statistics counter
//   STAT_MAX    : saturation value of the statistics counters
//   satInc      : saturating increment used by the statistics counters
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    STALL = 2'd2
  } arb_state_e;

  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  // Counters stick at their maximum rather than wrapping back to zero
  function automatic logic [STAT_W-1:0] satInc(input logic [STAT_W-1:0] value);
    return (value == STAT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// Combinational round-robin picker.
// Searches the request vector starting at rr_ptr_i and moving upward with
// wrap-around, and returns the first asserted request as a one-hot grant
// plus its binary index. When enable_i is low no grant is produced.
// Ports:
//   req_i    : request vector, one bit per producer
//   rr_ptr_i : index with the highest priority this cycle
//   enable_i : grant permission (FIFO has room, not in reset)
//   gnt_o    : one-hot grant (all zero when nothing is granted)
//   idx_o    : binary index of the granted producer (0 when none)
module fifo_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      rr_ptr_i,
  input  logic               enable_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      idx_o
);

  // Walk the candidates in priority order; the one extra sum bit lets the
  // pointer offset exceed NUM_REQ-1 before it is folded back into range,
  // which keeps non-power-of-two producer counts correct.
  always_comb begin
    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, rr_ptr_i} + (PW+1)'(off);
      if (sum >= (PW+1)'(NUM_REQ)) begin
        sum = sum - (PW+1)'(NUM_REQ);
      end
      cand = sum[PW-1:0];
      if (enable_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of a synchronous FIFO
// among NUM_REQ producers over a valid/ready handshake.
// A grant is only issued when the FIFO is guaranteed to have room, counting
// the write that is already in flight, so the FIFO can never overflow.
// The FIFO's write acknowledge and overflow flag are monitored and any
// anomaly raises a sticky error.
// Optional feature (macro FIFO_ARB_STATS_EN): per-producer grant counters
// and a stall-cycle counter; without the macro both outputs are tied to 0.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   req, req_data : producer valid bits and packed data slices
//   gnt           : combinational one-hot ready back to the producers
//   fifo_wr_en    : registered FIFO write enable
//   fifo_data_in  : registered FIFO write data
//   fifo_count    : FIFO occupancy
//   fifo_wr_ack   : FIFO write acknowledge (one cycle after a write)
//   fifo_overflow : FIFO overflow flag
//   err_clr       : synchronous clear of wr_err (and statistics)
//   wr_err        : sticky response error
//   arb_state     : registered FSM state
//   grant_cnt     : per-producer grant counters (statistics)
//   stall_cnt     : stall-cycle counter (statistics)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  input  logic                          err_clr,
  output logic                          wr_err,
  output logic [1:0]                    arb_state,
  output logic [NUM_REQ*STAT_W-1:0]     grant_cnt,
  output logic [STAT_W-1:0]             stall_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(NUM_REQ);

  arb_state_e            arbState_q, arbState_d;
  logic                  fifoWrEn_q, fifoWrEn_d;
  logic [FIFO_WIDTH-1:0] fifoData_q, fifoData_d;
  logic [PW-1:0]         rrPtr_q, rrPtr_d;
  logic                  wrErr_q, wrErr_d;
  logic                  wrEnPrev_q;

  logic [CW:0]           pending;
  logic                  space;
  logic                  pickEnable;
  logic [NUM_REQ-1:0]    pickGnt;
  logic [PW-1:0]         pickIdx;
  logic                  transfer;
  logic [FIFO_WIDTH-1:0] selData;
  logic                  errSet;

  // Room check: the write currently on fifo_wr_en is not yet visible in
  // fifo_count, so it is added in. Reads are ignored, which only ever makes
  // the check more cautious. Grants are also suppressed while in reset.
  assign pending    = {1'b0, fifo_count} + (CW+1)'(fifoWrEn_q);
  assign space      = pending < (CW+1)'(FIFO_DEPTH);
  assign pickEnable = space & rst_n;

  fifo_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) uPicker (
    .req_i    (req),
    .rr_ptr_i (rrPtr_q),
    .enable_i (pickEnable),
    .gnt_o    (pickGnt),
    .idx_o    (pickIdx)
  );

  assign gnt      = pickGnt;
  assign transfer = |(req & pickGnt);

  // Select the granted producer's data slice from the one-hot grant
  always_comb begin
    selData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pickGnt[i]) begin
        selData = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  // Next-state logic for the write path and the FSM. The next state depends
  // only on this cycle's activity, so the unused encoding naturally falls
  // back to a legal state after one cycle.
  always_comb begin
    fifoWrEn_d = transfer;
    fifoData_d = fifoData_q;
    rrPtr_d    = rrPtr_q;
    arbState_d = IDLE;
    if (transfer) begin
      fifoData_d = selData;
      rrPtr_d    = (pickIdx == PW'(NUM_REQ-1)) ? '0 : pickIdx + 1'b1;
      arbState_d = GRANT;
    end else if (|req) begin
      arbState_d = STALL;
    end
  end

  // Arbiter FSM and registered write port; reset drops any in-flight write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arbState_q <= IDLE;
      fifoWrEn_q <= 1'b0;
      fifoData_q <= '0;
      rrPtr_q    <= '0;
    end else begin
      arbState_q <= arbState_d;
      fifoWrEn_q <= fifoWrEn_d;
      fifoData_q <= fifoData_d;
      rrPtr_q    <= rrPtr_d;
    end
  end

  // A write issued last cycle must be acknowledged now; an overflow report
  // is always an error. Setting wins over a simultaneous clear.
  assign errSet = fifo_overflow | (wrEnPrev_q & ~fifo_wr_ack);

  always_comb begin
    wrErr_d = wrErr_q;
    if (errSet) begin
      wrErr_d = 1'b1;
    end else if (err_clr) begin
      wrErr_d = 1'b0;
    end
  end

  // Response checker: remembers last cycle's write and holds the error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrEnPrev_q <= 1'b0;
      wrErr_q    <= 1'b0;
    end else begin
      wrEnPrev_q <= fifoWrEn_q;
      wrErr_q    <= wrErr_d;
    end
  end

  assign fifo_wr_en   = fifoWrEn_q;
  assign fifo_data_in = fifoData_q;
  assign wr_err       = wrErr_q;
  assign arb_state    = arbState_q;

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] grantCnt_q;
  logic [STAT_W-1:0]              stallCnt_q;

  // Saturating statistics; err_clr restarts a measurement window and takes
  // precedence over any increment in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grantCnt_q <= '0;
      stallCnt_q <= '0;
    end else if (err_clr) begin
      grantCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && pickGnt[i]) begin
          grantCnt_q[i] <= satInc(grantCnt_q[i]);
        end
      end
      if (arbState_q == STALL) begin
        stallCnt_q <= satInc(stallCnt_q);
      end
    end
  end

  assign grant_cnt = grantCnt_q;
  assign stall_cnt = stallCnt_q;
`else
  assign grant_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter.
// A directed vector table covers the room boundary and the error flag; hand
// sequences cover reset, contention, a single streamer and reset during a
// write; a random phase compares every cycle against a behavioural model
// of the arbitration rules and a simple FIFO occupancy model.
// Statistics outputs are checked when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic [CW-1:0]  fifo_count;
  logic           fifo_wr_ack;
  logic           fifo_overflow;
  logic           err_clr;
  logic           wr_err;
  logic [1:0]     arb_state;
  logic [N*16-1:0] grant_cnt;
  logic [15:0]    stall_cnt;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_count    (fifo_count),
    .fifo_wr_ack   (fifo_wr_ack),
    .fifo_overflow (fifo_overflow),
    .err_clr       (err_clr),
    .wr_err        (wr_err),
    .arb_state     (arb_state),
    .grant_cnt     (grant_cnt),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state: what the arbiter should hold after each edge
  int          mPtr;
  bit          mWrEn;
  logic [15:0] mData;
  bit          mErr;
  int          mState;
  bit          mPrevWr;
  int          mGcnt[N];
  int          mStall;

  // FIFO environment model
  int          occ;
  bit          drain;
  bit          dropAck;
  bit          envOvfSeen;

  logic [N-1:0] sampledGnt;
  logic [1:0]   sampledState;

  typedef struct packed {
    logic [N-1:0]  req;
    logic [CW-1:0] cnt;
    logic          ack;
    logic          ovf;
    logic          clr;
    logic [N-1:0]  expGnt;
    logic          expWr;
    logic [15:0]   expData;
    logic [1:0]    expState;
    logic          expErr;
  } vec_t;

  vec_t tbl[10];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req           = v.req;
    fifo_count    = v.cnt;
    fifo_wr_ack   = v.ack;
    fifo_overflow = v.ovf;
    err_clr       = v.clr;
  endtask

  // First requesting producer at or after the pointer, or -1 when the FIFO
  // might not have room for another write
  function automatic int modelPick();
    if (!rst_n) return -1;
    if (int'(fifo_count) + int'(mWrEn) >= D) return -1;
    for (int off = 0; off < N; off++) begin
      int i = (mPtr + off) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic doReset();
    rst_n         = 1'b0;
    req           = '0;
    err_clr       = 1'b0;
    fifo_count    = '0;
    fifo_wr_ack   = 1'b0;
    fifo_overflow = 1'b0;
    drain         = 1'b0;
    dropAck       = 1'b0;
    occ           = 0;
    envOvfSeen    = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    mPtr = 0; mWrEn = 0; mData = '0; mErr = 0; mState = 0; mPrevWr = 0; mStall = 0;
    for (int i = 0; i < N; i++) mGcnt[i] = 0;
  endtask

  // One clock cycle: compare at the falling edge, advance model and FIFO
  // environment across the rising edge, return 1 time unit after it
  task automatic modelCycle();
    int           k;
    logic [N-1:0] expG;
    bit           wrBefore;
    bit           rd;
    bit           setErr;
    @(negedge clk);
    k    = modelPick();
    expG = (k >= 0) ? (N'(1) << k) : '0;
    checkOutput("gnt", gnt, expG);
    checkOutput("fifo_wr_en", fifo_wr_en, mWrEn);
    checkOutput("fifo_data_in", fifo_data_in, mData);
    checkOutput("arb_state", arb_state, mState);
    checkOutput("wr_err", wr_err, mErr);
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) checkOutput($sformatf("grant_cnt[%0d]", i), grant_cnt[i*16 +: 16], mGcnt[i]);
    checkOutput("stall_cnt", stall_cnt, mStall);
`else
    checkOutput("grant_cnt", grant_cnt, 0);
    checkOutput("stall_cnt", stall_cnt, 0);
`endif
    sampledGnt   = gnt;
    sampledState = arb_state;
    wrBefore     = fifo_wr_en;

    setErr = fifo_overflow || (mPrevWr && !fifo_wr_ack);
    if (err_clr) begin
      for (int i = 0; i < N; i++) mGcnt[i] = 0;
      mStall = 0;
    end else begin
      if (k >= 0 && mGcnt[k] < 65535) mGcnt[k]++;
      if (mState == 2 && mStall < 65535) mStall++;
    end
    mPrevWr = mWrEn;
    mErr    = setErr ? 1'b1 : (err_clr ? 1'b0 : mErr);
    if (k >= 0) begin
      mWrEn  = 1;
      mData  = req_data[k*W +: W];
      mPtr   = (k + 1) % N;
      mState = 1;
    end else begin
      mWrEn  = 0;
      mState = (req != '0) ? 2 : 0;
    end

    @(posedge clk);
    #1;
    rd = drain && occ > 0;
    if (wrBefore && occ == D && !rd) begin
      fifo_overflow = 1'b1;
      envOvfSeen    = 1'b1;
    end else begin
      fifo_overflow = 1'b0;
      occ = occ + int'(wrBefore) - int'(rd);
    end
    fifo_wr_ack = wrBefore && !dropAck;
    fifo_count  = CW'(occ);
  endtask

  initial begin
    int          order[$];
    int          stallSeen;
    logic [15:0] streamVal;

    // Directed table: room boundary, wrap of the pointer and error flag.
    // Registered expectations are the values visible during that row.
    tbl[0] = '{4'b0001, 4'd7, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 16'h0000, 2'd0, 1'b0};
    tbl[1] = '{4'b0001, 4'd7, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 16'h1000, 2'd1, 1'b0};
    tbl[2] = '{4'b0001, 4'd7, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 16'h1000, 2'd2, 1'b0};
    tbl[3] = '{4'b0000, 4'd8, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 16'h1000, 2'd1, 1'b1};
    tbl[4] = '{4'b0000, 4'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 16'h1000, 2'd0, 1'b1};
    tbl[5] = '{4'b0110, 4'd0, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 16'h1000, 2'd0, 1'b0};
    tbl[6] = '{4'b1010, 4'd1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 16'h1001, 2'd1, 1'b1};
    tbl[7] = '{4'b1010, 4'd2, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 16'h1003, 2'd1, 1'b1};
    tbl[8] = '{4'b0000, 4'd3, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 16'h1001, 2'd1, 1'b1};
    tbl[9] = '{4'b0000, 4'd3, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h1001, 2'd0, 1'b0};

    // Reset state with every producer requesting: nothing may be granted
    rst_n = 1'b0; req = '1; req_data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    err_clr = 0; fifo_count = '0; fifo_wr_ack = 0; fifo_overflow = 0;
    #3;
    checkOutput("reset gnt", gnt, 0);
    checkOutput("reset fifo_wr_en", fifo_wr_en, 0);
    checkOutput("reset arb_state", arb_state, 0);
    checkOutput("reset wr_err", wr_err, 0);

    $display("[TB] directed vector table");
    doReset();
    req_data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    for (int r = 0; r < 10; r++) begin
      applyStimulus(tbl[r]);
      @(negedge clk);
      checkOutput($sformatf("row%0d gnt", r), gnt, tbl[r].expGnt);
      checkOutput($sformatf("row%0d fifo_wr_en", r), fifo_wr_en, tbl[r].expWr);
      checkOutput($sformatf("row%0d fifo_data_in", r), fifo_data_in, tbl[r].expData);
      checkOutput($sformatf("row%0d arb_state", r), arb_state, tbl[r].expState);
      checkOutput($sformatf("row%0d wr_err", r), wr_err, tbl[r].expErr);
      @(posedge clk);
      #1;
    end

    $display("[TB] single streamer on producer 2");
    doReset();
    drain = 1'b1;
    streamVal = 16'hA5A5;
    req = 4'b0100;
    req_data[2*W +: W] = streamVal;
    for (int c = 0; c < 10; c++) begin
      modelCycle();
      checkOutput("stream gnt", sampledGnt, 4'b0100);
      if (sampledGnt[2]) begin
        streamVal = streamVal + 16'd1;
        req_data[2*W +: W] = streamVal;
      end
    end
    checkOutput("stream data lag", fifo_data_in, streamVal - 16'd1);

    // Reset while a write is on the port: it must vanish immediately
    checkOutput("pre-reset fifo_wr_en", fifo_wr_en, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset fifo_wr_en", fifo_wr_en, 0);
    checkOutput("midreset gnt", gnt, 0);
    checkOutput("midreset arb_state", arb_state, 0);
    checkOutput("midreset wr_err", wr_err, 0);

    $display("[TB] contention with all producers, FIFO never read");
    doReset();
    req = '1;
    req_data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    stallSeen = 0;
    for (int c = 0; c < 12; c++) begin
      modelCycle();
      if (sampledState == 2'd2) stallSeen++;
      for (int i = 0; i < N; i++) if (sampledGnt[i]) order.push_back(i);
    end
    checkOutput("contention writes", order.size(), 8);
    for (int j = 0; j < 8; j++) begin
      checkOutput($sformatf("contention order[%0d]", j), (j < order.size()) ? order[j] : -1, j % N);
    end
    checkOutput("contention arb_state", arb_state, 2);
    checkOutput("contention overflow", envOvfSeen, 0);
`ifdef FIFO_ARB_STATS_EN
    @(negedge clk);
    for (int i = 0; i < N; i++) checkOutput($sformatf("contention grant_cnt[%0d]", i), grant_cnt[i*16 +: 16], 2);
    checkOutput("contention stall_cnt", stall_cnt, stallSeen);
    @(posedge clk);
    #1;
`endif

    $display("[TB] randomized traffic");
    doReset();
    for (int c = 0; c < 600; c++) begin
      modelCycle();
      for (int i = 0; i < N; i++) begin
        if (req[i] && sampledGnt[i]) begin
          req[i] = 1'($urandom % 2);
          req_data[i*W +: W] = W'($urandom);
        end else if (!req[i] && ($urandom % 3 == 0)) begin
          req[i] = 1'b1;
          req_data[i*W +: W] = W'($urandom);
        end
      end
      drain   = ($urandom % 3 == 0);
      dropAck = ($urandom % 25 == 0);
      err_clr = ($urandom % 20 == 0);
    end
    checkOutput("random overflow", envOvfSeen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter in front of the synchronous FIFO (FIFO_WIDTH x FIFO_DEPTH). Shares the FIFO's single write port among NUM_REQ producers over a valid/ready handshake. Uses the FIFO's count to ensure no write is ever issued into a full FIFO, so overflow never occurs. Also checks wr_ack/overflow responses and raises a sticky error.

Parameters:
NUM_REQ, 4, number of producers (>=2)
FIFO_WIDTH, 16, data width, matches the FIFO
FIFO_DEPTH, 8, FIFO depth, matches the FIFO

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-producer write request (valid)
req_data  in  NUM_REQ*FIFO_WIDTH  per-producer data; slice i = bits [i*FIFO_WIDTH +: FIFO_WIDTH]
gnt  out  NUM_REQ  combinational one-hot ready; a transfer occurs on an edge where req[i]&gnt[i]
fifo_wr_en  out  1  registered FIFO write enable
fifo_data_in  out  FIFO_WIDTH  registered FIFO write data
fifo_count  in  $clog2(FIFO_DEPTH)+1  FIFO occupancy
fifo_wr_ack  in  1  FIFO write acknowledge
fifo_overflow  in  1  FIFO overflow flag
err_clr  in  1  synchronous clear for wr_err
wr_err  out  1  sticky response error
arb_state  out  2  registered FSM state
grant_cnt  out  NUM_REQ*16  per-producer grant counters (optional feature)
stall_cnt  out  16  stall-cycle counter (optional feature)

Behaviour:
- Reset, asynchronous and active-low, drives: fifo_wr_en=0, fifo_data_in=0, wr_err=0, arb_state=IDLE, rr_ptr=0, all counters=0. gnt is combinational and reads 0 during reset.
- Space check: space = (fifo_count + fifo_wr_en) < FIFO_DEPTH. fifo_wr_en counts the write not yet reflected in fifo_count. Concurrent FIFO reads are ignored, which is conservative.
- Arbitration: if space is true, gnt = one-hot of the first asserted req searching from rr_ptr upward with wrap. Otherwise gnt = 0.
- Only one gnt bit is ever high. No combinational path exists from gnt back to req.
- On a transfer edge for index k:
  - fifo_wr_en <= 1
  - fifo_data_in <= req_data slice k
  - rr_ptr <= (k+1) mod NUM_REQ
- With no transfer: fifo_wr_en <= 0, fifo_data_in holds, rr_ptr holds.
- Latency: req accepted in cycle t; FIFO write enable is high in cycle t+1.
- Throughput: 1 write per cycle while space holds.
- Producer rule: req[i] and its data must stay stable until gnt[i]. The producer may drop req, or present new data, on the cycle after acceptance.
- FSM (arb_state, next state computed every cycle):
  - IDLE (0): next state when no req is asserted.
  - GRANT (1): next state when a transfer occurs this cycle.
  - STALL (2): next state when some req is asserted and space is false.
  - Encoding 3 is unused and recovers to IDLE.
- Response check: wr_err <= 1 when fifo_overflow=1, or when fifo_wr_en was 1 in the previous cycle and fifo_wr_ack=0 now.
  - err_clr=1 clears wr_err.
  - Set has priority over clear in the same cycle.
- Boundaries:
  - fifo_count = FIFO_DEPTH-1 with fifo_wr_en=1: no grant.
  - fifo_count = FIFO_DEPTH: no grant.
  - NUM_REQ-1 wraps to 0.
  - A single requester is granted every cycle.
  - Reset mid-transfer drops the in-flight write: fifo_wr_en=0 immediately.

Optional Feature:
FIFO_ARB_STATS_EN
- Defined:
  - grant_cnt slice i increments on each transfer from producer i.
  - stall_cnt increments each cycle arb_state=STALL.
  - Both saturate at 16'hFFFF and are cleared by reset or err_clr.
- Undefined: grant_cnt and stall_cnt are tied to 0 and no counter flops are generated.

Decomposition:
- Package fifo_arb_pkg holds:
  - arb_state_e enum (IDLE=2'd0, GRANT=2'd1, STALL=2'd2)
  - STAT_W=16
  - STAT_MAX constant
- One combinational sub-module, fifo_rr_picker, parameterised by NUM_REQ:
  - inputs: req vector, rr_ptr, enable (= space)
  - outputs: one-hot gnt, binary index

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> fifo_wr_en=0, wr_err=0, arb_state=IDLE, gnt=0 asynchronously. After release, first grant to req[0] when all req are asserted.
- Contention: NUM_REQ=4, req=4'b1111, FIFO never read -> gnt order 0,1,2,3,0,1,2,3. Exactly 8 writes, then gnt=0, arb_state=STALL, fifo_overflow never asserted.
- Single streamer: only req[2] asserted, data 16'hA5A5,16'hA5A6,... with FIFO draining -> gnt[2]=1 every cycle. fifo_wr_en high back-to-back and fifo_data_in matches the sequence one cycle late.
- Space edge: fifo_count=7 with fifo_wr_en=1 -> gnt=0 this cycle. Next cycle with fifo_count=7, fifo_wr_en=0 -> one grant issued.
- Error: force fifo_wr_ack=0 the cycle after a write -> wr_err=1 next edge and stays 1. Pulse err_clr -> wr_err=0. A fifo_overflow pulse coincident with err_clr -> wr_err=1.
- Stats (FIFO_ARB_STATS_EN): after the contention scenario, grant_cnt = 2 per producer and stall_cnt = number of STALL cycles observed.
